duo_pixel_painter: RTL

DUO_PIXEL_PAINTER -- requirements
Module: duo_pixel_painter

---
 rtl/duo_pixel_painter_pkg.sv | 28 ++
 rtl/duo_pixel_painter_nibble_to_rgb565.sv | 27 ++
 rtl/duo_pixel_painter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/duo_pixel_painter_pkg.sv
// Shared definitions for the duo pixel painter.
// Holds the pattern ids, the controller states, the colour tint select
// and the RGB565 black constant used for blanked and out-of-range pixels.
package duo_pixel_painter_pkg;

   // Pattern ids in rotation order. Advancing from BORDER wraps back to SPLIT.
   typedef enum logic [1:0] {
      PAT_SPLIT   = 2'd0,
      PAT_STRIPES = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_BORDER  = 2'd3
   } pattern_e;

   // Controller states. WAIT_FRAME blanks every pixel until the first frame_begin.
   typedef enum logic {
      ST_WAIT_FRAME = 1'b0,
      ST_RUN        = 1'b1
   } state_e;

   // Tint applied when a 4-bit intensity is expanded to RGB565.
   typedef enum logic {
      TINT_GREY = 1'b0,
      TINT_CYAN = 1'b1
   } tint_e;

   localparam logic [15:0] RGB565_BLACK = 16'h0000;

endpackage

// File: rtl/duo_pixel_painter_nibble_to_rgb565.sv
// Expands a 4-bit intensity into an RGB565 colour.
// Ports:
//   nibble - 4-bit intensity
//   tint   - TINT_GREY drives all three channels, TINT_CYAN leaves red at zero
//   rgb    - RGB565 result {R[4:0], G[5:0], B[4:0]}
// Low bits of each channel replicate the top of the nibble, so 4'hF maps to
// full scale and 4'h0 maps to zero.
module nibble_to_rgb565
   import duo_pixel_painter_pkg::*;
(
   input  logic [3:0]  nibble,
   input  tint_e       tint,
   output logic [15:0] rgb
);

   logic [4:0] red;
   logic [5:0] green;
   logic [4:0] blue;

   always_comb begin
      green = {nibble, nibble[3:2]};
      blue  = {nibble, nibble[3]};
      red   = (tint == TINT_GREY) ? {nibble, nibble[3]} : 5'd0;
      rgb   = {red, green, blue};
   end

endmodule

// File: rtl/duo_pixel_painter.sv
// Two-colour test pattern generator feeding an OLED driver.
// A pair of 4-bit intensities (duo) is latched on every frame_begin: nibble A
// becomes a grey colour, nibble B a cyan colour. Each sampled pixel is painted
// A or B according to the current pattern; patterns rotate every
// FRAMES_PER_PATTERN frames unless freeze is high.
// Ports:
//   clk, rst_n            - clock and asynchronous active-low reset
//   duo                   - {nibble A, nibble B}, latched on frame_begin
//   frame_begin           - pulse before pixel 0 of each frame
//   sample_pixel          - strobe requesting the colour of pixel_index
//   pixel_index           - linear pixel index y*WIDTH + x
//   freeze                - holds pattern rotation
//   pixel_data            - registered RGB565 colour, held between samples
//   pixel_valid           - one-cycle pulse qualifying pixel_data
//   pattern, frame_cnt    - current pattern id and frames shown in it
module duo_pixel_painter
   import duo_pixel_painter_pkg::*;
#(
   parameter int WIDTH              = 96,
   parameter int HEIGHT             = 64,
   parameter int FRAMES_PER_PATTERN = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  duo,
   input  logic        frame_begin,
   input  logic        sample_pixel,
   input  logic [12:0] pixel_index,
   input  logic        freeze,
   output logic [15:0] pixel_data,
   output logic        pixel_valid,
   output logic [1:0]  pattern,
   output logic [4:0]  frame_cnt
);

   localparam logic [12:0] WIDTH_C     = 13'(WIDTH);
   localparam logic [12:0] HALF_WIDTH  = 13'(WIDTH / 2);
   localparam logic [12:0] LAST_X      = 13'(WIDTH - 1);
   localparam logic [12:0] LAST_Y      = 13'(HEIGHT - 1);
   localparam logic [12:0] NUM_PIXELS  = 13'(WIDTH * HEIGHT);
   localparam logic [4:0]  LAST_FRAME  = 5'(FRAMES_PER_PATTERN - 1);

   state_e      state_q, state_d;
   pattern_e    pattern_q, pattern_d;
   logic [4:0]  frame_cnt_q, frame_cnt_d;
   logic [3:0]  pal_a_q, pal_a_d;
   logic [3:0]  pal_b_q, pal_b_d;
   logic [15:0] pixel_data_q, pixel_data_d;
   logic        pixel_valid_q, pixel_valid_d;

   logic [12:0] x_pos;
   logic [12:0] y_pos;
   logic        sel_a;
   logic [15:0] colour_a;
   logic [15:0] colour_b;

   // Frame-level control. The *_d values are also what the pixel path uses,
   // so a sample coinciding with frame_begin sees the fresh palette and the
   // already-advanced pattern.
   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      frame_cnt_d = frame_cnt_q;
      pal_a_d     = pal_a_q;
      pal_b_d     = pal_b_q;
      if (frame_begin) begin
         pal_a_d = duo[7:4];
         pal_b_d = duo[3:0];
         case (state_q)
            ST_WAIT_FRAME: begin
               frame_cnt_d = 5'd0;
               state_d     = ST_RUN;
            end
            ST_RUN: begin
               if (!freeze) begin
                  if (frame_cnt_q == LAST_FRAME) begin
                     frame_cnt_d = 5'd0;
                     pattern_d   = pattern_e'(pattern_q + 2'd1);
                  end else begin
                     frame_cnt_d = frame_cnt_q + 5'd1;
                  end
               end
            end
            default: state_d = ST_WAIT_FRAME;
         endcase
      end
   end

   // Constant divisor, so synthesis reduces these to fixed arithmetic.
   always_comb begin
      x_pos = pixel_index % WIDTH_C;
      y_pos = pixel_index / WIDTH_C;
   end

   nibble_to_rgb565 u_colour_a (
      .nibble (pal_a_d),
      .tint   (TINT_GREY),
      .rgb    (colour_a)
   );

   nibble_to_rgb565 u_colour_b (
      .nibble (pal_b_d),
      .tint   (TINT_CYAN),
      .rgb    (colour_b)
   );

   // Pattern geometry: sel_a picks colour A, otherwise colour B.
   always_comb begin
      sel_a = 1'b0;
      case (pattern_d)
         PAT_SPLIT:   sel_a = (x_pos < HALF_WIDTH);
         PAT_STRIPES: sel_a = ~x_pos[3];
         PAT_CHECKER: sel_a = ~(x_pos[3] ^ y_pos[3]);
         PAT_BORDER:  sel_a = (x_pos == 13'd0) || (x_pos == LAST_X) ||
                              (y_pos == 13'd0) || (y_pos == LAST_Y);
         default:     sel_a = 1'b0;
      endcase
   end

   // Pixels are blanked until a frame has started and beyond the panel area.
   always_comb begin
      pixel_data_d  = pixel_data_q;
      pixel_valid_d = sample_pixel;
      if (sample_pixel) begin
         if ((state_d == ST_RUN) && (pixel_index < NUM_PIXELS)) begin
            pixel_data_d = sel_a ? colour_a : colour_b;
         end else begin
            pixel_data_d = RGB565_BLACK;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_WAIT_FRAME;
         pattern_q     <= PAT_SPLIT;
         frame_cnt_q   <= 5'd0;
         pal_a_q       <= 4'd0;
         pal_b_q       <= 4'd0;
         pixel_data_q  <= RGB565_BLACK;
         pixel_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pattern_q     <= pattern_d;
         frame_cnt_q   <= frame_cnt_d;
         pal_a_q       <= pal_a_d;
         pal_b_q       <= pal_b_d;
         pixel_data_q  <= pixel_data_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   assign pixel_data  = pixel_data_q;
   assign pixel_valid = pixel_valid_q;
   assign pattern     = pattern_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
